ad_frame_rx: RTL and testbench

Serial ADC frame receiver, directly downstream of the ad_top serial clock generator. It consumes the generator's one-cycle `pluse` strobe, which marks each serial-clock rising edge. It drives the ADC chip select and shifts in `DW` bits of `ad_sdo` MSB-first, one bit per strobe. Each completed word is presented on a parallel bus with a one-cycle valid. The block sits between the clock generator and the sample FIFO/packetizer in ad_top.

---
 rtl/ad_frame_rx.sv | 131 +++++++++++++
 tb/tb_ad_frame_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_frame_rx.sv
// Serial ADC frame receiver: frames ad_cs_n around DW serial-clock strobes and
// shifts ad_sdo in MSB-first, presenting each completed word with a one-cycle valid.
module ad_frame_rx #(
    parameter int DW  = 16,
    parameter int GAP = 2
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          pluse,
    input  logic          ad_sdo,
    input  logic          trig,
    output logic          ad_cs_n,
    output logic [DW-1:0] data,
    output logic          data_vld,
    output logic          busy,
    output logic          ovr
);
    localparam int BW = $clog2(DW);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [BW-1:0] bit_cnt_r;
    logic [BW-1:0] bit_cnt_nxt_s;
    logic [GW-1:0] gap_cnt_r;
    logic [GW-1:0] gap_cnt_nxt_s;
    logic [DW-1:0] sr_r;
    logic [DW-1:0] sr_nxt_s;
    logic [DW-1:0] data_nxt_s;
    logic [DW-1:0] shifted_s;
    logic          cs_nxt_s;
    logic          vld_nxt_s;

    assign shifted_s = {sr_r[DW-2:0], ad_sdo};

    // State, counters, shift register and all outputs are registered here.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
            sr_r      <= '0;
            ad_cs_n   <= 1'b1;
            data      <= '0;
            data_vld  <= 1'b0;
            busy      <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
            sr_r      <= sr_nxt_s;
            ad_cs_n   <= cs_nxt_s;
            data      <= data_nxt_s;
            data_vld  <= vld_nxt_s;
            busy      <= (state_nxt_s != IDLE);
            // Any request outside IDLE is dropped, including the last HOLD cycle.
            ovr       <= trig & (state_r != IDLE);
        end
    end

    // Next-state logic; nothing advances except on a pluse strobe once framing starts.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        sr_nxt_s      = sr_r;
        cs_nxt_s      = ad_cs_n;
        data_nxt_s    = data;
        vld_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (trig) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (pluse) begin
                    cs_nxt_s      = 1'b0;
                    bit_cnt_nxt_s = '0;
                    state_nxt_s   = SHIFT;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            SHIFT: begin
                if (pluse) begin
                    sr_nxt_s      = shifted_s;
                    bit_cnt_nxt_s = bit_cnt_r + BW'(1);
                    if (bit_cnt_r == BW'(DW - 1)) begin
                        data_nxt_s    = shifted_s;
                        vld_nxt_s     = 1'b1;
                        cs_nxt_s      = 1'b1;
                        gap_cnt_nxt_s = '0;
                        state_nxt_s   = HOLD;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            HOLD: begin
                if (pluse) begin
                    gap_cnt_nxt_s = gap_cnt_r + GW'(1);
                    if (gap_cnt_r == GW'(GAP - 1)) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cs_nxt_s    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ad_frame_rx.sv
// Bench for ad_frame_rx: a DW=16/GAP=2 and a DW=12/GAP=1 instance share stimulus and
// are compared every cycle against a cycle-number schedule model of the frame timing.
module tb_ad_frame_rx;
    logic        clk_sys = 1'b0;
    logic        rst;
    logic        pluse;
    logic        ad_sdo;
    logic        trig;
    logic        cs16, vld16, busy16, ovr16;
    logic [15:0] data16;
    logic        cs12, vld12, busy12, ovr12;
    logic [11:0] data12;

    int n_checks = 0;
    int n_fail   = 0;

    bit          adc_mode = 1'b0;
    logic [15:0] adc_word = 16'h0000;
    int          cs_low16 = 0;
    int          vld_cnt16 = 0;
    int          ovr_cnt16 = 0;

    always #5 clk_sys = ~clk_sys;

    ad_frame_rx #(.DW(16), .GAP(2)) dut16 (
        .clk_sys(clk_sys), .rst(rst), .pluse(pluse), .ad_sdo(ad_sdo), .trig(trig),
        .ad_cs_n(cs16), .data(data16), .data_vld(vld16), .busy(busy16), .ovr(ovr16)
    );

    ad_frame_rx #(.DW(12), .GAP(1)) dut12 (
        .clk_sys(clk_sys), .rst(rst), .pluse(pluse), .ad_sdo(ad_sdo), .trig(trig),
        .ad_cs_n(cs12), .data(data12), .data_vld(vld12), .busy(busy12), .ovr(ovr12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Strobe generator (period 4, random phase) and an ADC that shifts after each strobe.
    initial begin
        int ptr;
        int ncnt;
        int phase;
        logic prev_cs;
        ptr     = 15;
        ncnt    = 0;
        prev_cs = 1'b1;
        phase   = $urandom_range(0, 3);
        pluse   = 1'b0;
        ad_sdo  = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (adc_mode) begin
                if (cs16 !== 1'b0) ptr = 15;
                else if (prev_cs == 1'b0 && pluse && ptr > 0) ptr--;
                ad_sdo = adc_word[ptr];
            end else begin
                ad_sdo = 1'($urandom_range(0, 1));
            end
            prev_cs = cs16;
            pluse   = ((ncnt % 4) == phase);
            ncnt++;
        end
    end

    // Reference model: each accepted trigger fixes t0 and every output follows from cycle arithmetic.
    initial begin
        int          dw [2];
        int          gp [2];
        int          t0 [2];
        bit          pend [2];
        logic [31:0] acc [2];
        logic [31:0] dexp [2];
        int n, m, cyc;
        bit idle, cs_e, vld_e, busy_e, ovr_e;
        logic o_cs, o_vld, o_busy, o_ovr;
        logic [31:0] o_data, mask;
        dw = '{16, 12};
        gp = '{2, 1};
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            t0[i] = -1; pend[i] = 1'b0; acc[i] = 32'd0; dexp[i] = 32'd0;
        end
        forever begin
            @(posedge clk_sys);
            #1;
            n = cyc;
            m = n + 1;
            for (int i = 0; i < 2; i++) begin
                ovr_e = 1'b0;
                if (rst) begin
                    t0[i] = -1; pend[i] = 1'b0; acc[i] = 32'd0; dexp[i] = 32'd0;
                end else begin
                    idle = !(pend[i] || (t0[i] >= 0 && n < t0[i] + 4*dw[i] + 4*gp[i] + 1));
                    if (pend[i] && pluse) begin
                        t0[i] = n; pend[i] = 1'b0; acc[i] = 32'd0;
                    end
                    if (t0[i] >= 0 && n > t0[i] && n <= t0[i] + 4*dw[i] && ((n - t0[i]) % 4) == 0)
                        acc[i] = (acc[i] << 1) | {31'd0, ad_sdo};
                    if (trig) begin
                        if (idle) pend[i] = 1'b1;
                        else ovr_e = 1'b1;
                    end
                end
                cs_e   = !(t0[i] >= 0 && m >= t0[i] + 1 && m <= t0[i] + 4*dw[i]);
                vld_e  = (t0[i] >= 0 && m == t0[i] + 4*dw[i] + 1);
                busy_e = pend[i] || (t0[i] >= 0 && m < t0[i] + 4*dw[i] + 4*gp[i] + 1);
                mask   = (32'd1 << dw[i]) - 32'd1;
                if (vld_e) dexp[i] = acc[i] & mask;
                if (i == 0) begin
                    o_cs = cs16; o_vld = vld16; o_busy = busy16; o_ovr = ovr16; o_data = {16'd0, data16};
                end else begin
                    o_cs = cs12; o_vld = vld12; o_busy = busy12; o_ovr = ovr12; o_data = {20'd0, data12};
                end
                check($sformatf("cs_n[DW%0d] c%0d", dw[i], m), {31'd0, o_cs}, {31'd0, cs_e});
                check($sformatf("data_vld[DW%0d] c%0d", dw[i], m), {31'd0, o_vld}, {31'd0, vld_e});
                check($sformatf("busy[DW%0d] c%0d", dw[i], m), {31'd0, o_busy}, {31'd0, busy_e});
                check($sformatf("ovr[DW%0d] c%0d", dw[i], m), {31'd0, o_ovr}, {31'd0, ovr_e});
                check($sformatf("data[DW%0d] c%0d", dw[i], m), o_data, dexp[i]);
            end
            if (cs16 == 1'b0) cs_low16++;
            if (vld16) vld_cnt16++;
            if (ovr16) ovr_cnt16++;
            cyc++;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy16 || busy12) && k < 300) begin
            @(negedge clk_sys);
            k++;
        end
        check("idle_timeout", {31'd0, (k < 300)}, 32'd1);
    endtask

    task automatic frame(input logic [15:0] word);
        adc_mode  = 1'b1;
        adc_word  = word;
        cs_low16  = 0;
        vld_cnt16 = 0;
        @(negedge clk_sys);
        trig = 1'b1;
        @(negedge clk_sys);
        trig = 1'b0;
        wait_idle();
        check("frame_data16", {16'd0, data16}, {16'd0, word});
        check("frame_data12", {20'd0, data12}, {20'd0, word[15:4]});
        check("frame_cs_low_cycles", cs_low16, 32'd64);
        check("frame_vld_count", vld_cnt16, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst  = 1'b0;
        trig = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        repeat (2) @(negedge clk_sys);

        frame(16'hA5C3);

        ovr_cnt16 = 0;
        wait_idle();
        frame(16'hFFFF);
        frame(16'h0001);
        check("b2b_ovr_count", ovr_cnt16, 32'd0);

        adc_mode = 1'b0;
        vld_cnt16 = 0;
        @(negedge clk_sys);
        trig = 1'b1;
        repeat (400) @(negedge clk_sys);
        trig = 1'b0;
        check("held_trig_frames", {31'd0, (vld_cnt16 >= 5)}, 32'd1);
        wait_idle();

        adc_mode = 1'b1;
        adc_word = 16'h3C5A;
        @(negedge clk_sys);
        trig = 1'b1;
        @(negedge clk_sys);
        trig = 1'b0;
        k = 0;
        while (!vld16 && k < 200) begin
            @(negedge clk_sys);
            k++;
        end
        check("vld_timeout", {31'd0, (k < 200)}, 32'd1);
        repeat (7) @(negedge clk_sys);
        trig = 1'b1;
        @(negedge clk_sys);
        trig = 1'b0;
        check("last_hold_ovr", {31'd0, ovr16}, 32'd1);
        check("last_hold_busy", {31'd0, busy16}, 32'd0);
        repeat (4) @(negedge clk_sys);
        check("last_hold_no_frame", {31'd0, busy16}, 32'd0);
        wait_idle();

        adc_word = 16'h1234;
        @(negedge clk_sys);
        trig = 1'b1;
        @(negedge clk_sys);
        trig = 1'b0;
        k = 0;
        while (cs16 && k < 20) begin
            @(negedge clk_sys);
            k++;
        end
        check("cs_fall_timeout", {31'd0, (k < 20)}, 32'd1);
        repeat (35) @(negedge clk_sys);
        rst = 1'b1;
        #1;
        check("rst_cs_n", {31'd0, cs16}, 32'd1);
        check("rst_busy", {31'd0, busy16}, 32'd0);
        check("rst_data", {16'd0, data16}, 32'd0);
        check("rst_vld", {31'd0, vld16}, 32'd0);
        check("rst_busy12", {31'd0, busy12}, 32'd0);
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        frame(16'h8F10);

        repeat (3) frame(16'($urandom));

        repeat (5) @(negedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
